mm_sequencer: RTL and testbench

MM_SEQUENCER -- requirements
Module: mm_sequencer

---
 rtl/mm_pkg.sv | 20 ++
 rtl/mm_xpose_buf.sv | 58 +++++
 rtl/mm_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mm_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg
//   Shared definitions for the matrix-vector sequencer slice.
//   Holds the default element width, matrix dimension and compute-wait
//   limit, plus the sequencer state encoding.
package mm_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_WAIT_MAX   = 24;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FILL,
    WAIT,
    CAPTURE,
    CLR
  } state_t;

endpackage

// File: rtl/mm_xpose_buf.sv
// mm_xpose_buf
//   (DEPTH+1)-word store. Words 0..DEPTH-1 hold the rows of A, word DEPTH
//   holds B. Rows are written whole; reads return one column of A together
//   with the matching element of B, which turns the row-major memory
//   layout into the column stream the datapath consumes.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (clears all words)
//   wr_en      : write one word
//   wr_row     : word index to write (0..DEPTH)
//   wr_data    : word data, element j in bits [j*DATA_WIDTH +: DATA_WIDTH]
//   rd_col     : column index to read (0..DEPTH-1)
//   rd_a       : rd_a[i] = A[i][rd_col]
//   rd_b       : B[rd_col]
module mm_xpose_buf
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int ROW_W     = $clog2(DEPTH + 1),
  localparam int COL_W     = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [ROW_W-1:0]                    wr_row,
  input  logic [DEPTH*DATA_WIDTH-1:0]         wr_data,
  input  logic [COL_W-1:0]                    rd_col,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]    rd_a,
  output logic [DATA_WIDTH-1:0]               rd_b
);

  logic [DEPTH*DATA_WIDTH-1:0] words [DEPTH+1];

  // Row write port. Out-of-range row indices are dropped so a stray
  // write can never land outside the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r <= DEPTH; r++) begin
        words[r] <= '0;
      end
    end else if (wr_en && (wr_row <= ROW_W'(DEPTH))) begin
      words[wr_row] <= wr_data;
    end
  end

  // Column read: pick the same element position out of every A row and
  // out of the B word.
  always_comb begin
    int unsigned col_base;
    col_base = int'(rd_col) * DATA_WIDTH;
    for (int i = 0; i < DEPTH; i++) begin
      rd_a[i] = words[i][col_base +: DATA_WIDTH];
    end
    rd_b = words[DEPTH][col_base +: DATA_WIDTH];
  end

endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer
//   Runs one matrix-vector multiply per start pulse: fetches DEPTH rows of
//   A plus the B vector from memory, streams A column by column with the
//   matching B element into the MAC datapath, waits for the datapath (or a
//   timeout), captures the accumulators into result and clears the
//   datapath.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : one-cycle run request, honoured only in IDLE
//   base_addr        : word address of A row 0; B sits at base_addr+DEPTH
//   busy             : high whenever the sequencer is not IDLE
//   result_valid     : one-cycle pulse, result holds a new vector
//   result           : captured product vector, held until next capture
//   mem_read         : read request, held with mem_addr while stalled
//   mem_addr         : read word address
//   mem_waitrequest  : memory stall
//   mem_rdata        : read data, element j in byte lane j
//   mem_rvalid       : read data valid, responses arrive in order
//   mm_wren          : datapath FIFO write strobe (FILL only)
//   mm_clr           : datapath accumulator clear (CLR only)
//   mm_a_mat         : one column of A
//   mm_b_vec         : one element of B
//   mm_done          : datapath done level
//   mm_sum           : datapath accumulators
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = 32,
  parameter int WAIT_MAX   = DEF_WAIT_MAX
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic [DEPTH-1:0][3*DATA_WIDTH-1:0]   result,
  output logic                                 mem_read,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic                                 mem_waitrequest,
  input  logic [DEPTH*DATA_WIDTH-1:0]          mem_rdata,
  input  logic                                 mem_rvalid,
  output logic                                 mm_wren,
  output logic                                 mm_clr,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]     mm_a_mat,
  output logic [DATA_WIDTH-1:0]                mm_b_vec,
  input  logic                                 mm_done,
  input  logic [DEPTH-1:0][3*DATA_WIDTH-1:0]   mm_sum
);

  localparam int CNT_W  = $clog2(DEPTH + 2);
  localparam int ROW_W  = $clog2(DEPTH + 1);
  localparam int COL_W  = $clog2(DEPTH);
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  state_t                          state;
  logic [CNT_W-1:0]                iss_cnt;
  logic [CNT_W-1:0]                rcv_cnt;
  logic [COL_W-1:0]                fill_cnt;
  logic [WCNT_W-1:0]               wait_cnt;
  logic                            buf_wr;
  logic [COL_W-1:0]                col_sel;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] col_a;
  logic [DATA_WIDTH-1:0]           col_b;

  assign busy = (state != IDLE);

  // Buffer control. Responses are only stored while fetching and only up
  // to the expected DEPTH+1. The read column runs one ahead of the FILL
  // counter because the output registers load the next column each cycle;
  // outside FILL it rests on column 0 so the first column is ready on the
  // FETCH-to-FILL edge.
  always_comb begin
    buf_wr  = (state == FETCH) && mem_rvalid && (rcv_cnt <= CNT_W'(DEPTH));
    col_sel = '0;
    if ((state == FILL) && (fill_cnt != COL_W'(DEPTH - 1))) begin
      col_sel = fill_cnt + COL_W'(1);
    end
  end

  mm_xpose_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_xpose_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_row  (ROW_W'(rcv_cnt)),
    .wr_data (mem_rdata),
    .rd_col  (col_sel),
    .rd_a    (col_a),
    .rd_b    (col_b)
  );

  // Sequencer FSM with all counters and registered outputs.
  // FETCH tracks issued and received reads separately so requests can be
  // pipelined ahead of responses. The last response is B itself, which is
  // being written into the buffer on the same edge, so B[0] for the first
  // FILL cycle is taken straight from mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      iss_cnt      <= '0;
      rcv_cnt      <= '0;
      fill_cnt     <= '0;
      wait_cnt     <= '0;
      mem_read     <= 1'b0;
      mem_addr     <= '0;
      mm_wren      <= 1'b0;
      mm_clr       <= 1'b0;
      mm_a_mat     <= '0;
      mm_b_vec     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            mem_addr <= base_addr;
            mem_read <= 1'b1;
            iss_cnt  <= '0;
            rcv_cnt  <= '0;
          end
        end

        FETCH: begin
          if (mem_read && !mem_waitrequest) begin
            iss_cnt <= iss_cnt + CNT_W'(1);
            if (iss_cnt == CNT_W'(DEPTH)) begin
              mem_read <= 1'b0;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          if (buf_wr) begin
            rcv_cnt <= rcv_cnt + CNT_W'(1);
            if (rcv_cnt == CNT_W'(DEPTH)) begin
              state    <= FILL;
              mem_read <= 1'b0;
              mm_wren  <= 1'b1;
              fill_cnt <= '0;
              mm_a_mat <= col_a;
              mm_b_vec <= mem_rdata[DATA_WIDTH-1:0];
            end
          end
        end

        FILL: begin
          if (fill_cnt == COL_W'(DEPTH - 1)) begin
            state    <= WAIT;
            mm_wren  <= 1'b0;
            mm_a_mat <= '0;
            mm_b_vec <= '0;
            wait_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + COL_W'(1);
            mm_a_mat <= col_a;
            mm_b_vec <= col_b;
          end
        end

        WAIT: begin
          if (mm_done || (wait_cnt == WCNT_W'(WAIT_MAX - 1))) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end

        CAPTURE: begin
          result       <= mm_sum;
          mm_clr       <= 1'b1;
          result_valid <= 1'b1;
          state        <= CLR;
        end

        CLR: begin
          mm_clr       <= 1'b0;
          result_valid <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer
//   Directed bench for mm_sequencer: a one-cycle-latency memory model with
//   an optional stall on the fifth read, a small MAC datapath model that
//   raises done three cycles after its last write unless the last B
//   element is zero, and hand-computed expected values.
module tb_mm_sequencer;

  localparam int DW       = 8;
  localparam int DEPTH    = 8;
  localparam int AW       = 32;
  localparam int WAIT_MAX = 24;
  localparam int SW       = 3 * DW;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        start;
  logic [AW-1:0]               base_addr;
  logic                        busy;
  logic                        result_valid;
  logic [DEPTH-1:0][SW-1:0]    result;
  logic                        mem_read;
  logic [AW-1:0]               mem_addr;
  logic                        mem_waitrequest;
  logic [DEPTH*DW-1:0]         mem_rdata;
  logic                        mem_rvalid;
  logic                        mm_wren;
  logic                        mm_clr;
  logic [DEPTH-1:0][DW-1:0]    mm_a_mat;
  logic [DW-1:0]               mm_b_vec;
  logic                        mm_done;
  logic [DEPTH-1:0][SW-1:0]    mm_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_sequencer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW),
    .WAIT_MAX   (WAIT_MAX)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .busy            (busy),
    .result_valid    (result_valid),
    .result          (result),
    .mem_read        (mem_read),
    .mem_addr        (mem_addr),
    .mem_waitrequest (mem_waitrequest),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .mm_wren         (mm_wren),
    .mm_clr          (mm_clr),
    .mm_a_mat        (mm_a_mat),
    .mm_b_vec        (mm_b_vec),
    .mm_done         (mm_done),
    .mm_sum          (mm_sum)
  );

  // Memory model: accepts a read whenever it is not stalling and returns
  // the word one cycle later. With stalls enabled the fifth read of a run
  // is held off for three cycles.
  logic [63:0]   mem_img [64];
  logic          stall_en;
  logic [AW-1:0] stall_exp_addr;
  int            acc_cnt;
  int            stall_left;

  assign mem_waitrequest = stall_en && (acc_cnt == 4) && (stall_left != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      acc_cnt    <= 0;
      stall_left <= 0;
    end else begin
      mem_rvalid <= 1'b0;
      if (start) begin
        acc_cnt    <= 0;
        stall_left <= 3;
      end else if (mem_read && !mem_waitrequest) begin
        acc_cnt    <= acc_cnt + 1;
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem_img[mem_addr[5:0]];
      end
      if (mem_waitrequest) begin
        stall_left <= stall_left - 1;
      end
    end
  end

  // Datapath model: accumulates a[i]*b per write, clears on mm_clr.
  logic [DEPTH-1:0][SW-1:0] dp_sum;
  int                       dp_wr;
  int                       dp_dly;
  logic                     dp_done;

  assign mm_sum  = dp_sum;
  assign mm_done = dp_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sum  <= '0;
      dp_wr   <= 0;
      dp_dly  <= 0;
      dp_done <= 1'b0;
    end else if (mm_clr) begin
      dp_sum  <= '0;
      dp_wr   <= 0;
      dp_dly  <= 0;
      dp_done <= 1'b0;
    end else begin
      if (mm_wren) begin
        for (int i = 0; i < DEPTH; i++) begin
          dp_sum[i] <= dp_sum[i] + SW'(mm_a_mat[i]) * SW'(mm_b_vec);
        end
        dp_wr <= dp_wr + 1;
        if ((dp_wr == DEPTH - 1) && (mm_b_vec != '0)) begin
          dp_dly <= 3;
        end
      end
      if (dp_dly != 0) begin
        dp_dly <= dp_dly - 1;
        if (dp_dly == 1) begin
          dp_done <= 1'b1;
        end
      end
    end
  end

  // Cumulative event counters sampled mid-cycle; steps compare deltas.
  int          rv_total    = 0;
  int          clr_total   = 0;
  int          tog_total   = 0;
  int          wren_total  = 0;
  int          wren_runs   = 0;
  int          acc_total   = 0;
  int          stall_total = 0;
  int          stall_bad   = 0;
  int          fill_idx    = 0;
  logic        wren_d      = 1'b0;
  logic [63:0] fill_a [8];
  logic [7:0]  fill_b [8];

  always @(negedge clk) begin
    wren_d <= mm_wren;
    if (result_valid) rv_total <= rv_total + 1;
    if (mm_clr) clr_total <= clr_total + 1;
    if (result_valid && mm_clr) tog_total <= tog_total + 1;
    if (mem_read && !mem_waitrequest) acc_total <= acc_total + 1;
    if (mem_waitrequest) begin
      stall_total <= stall_total + 1;
      if (!mem_read || (mem_addr != stall_exp_addr)) stall_bad <= stall_bad + 1;
    end
    if (mm_wren) begin
      wren_total <= wren_total + 1;
      if (!wren_d) begin
        wren_runs  <= wren_runs + 1;
        fill_a[0]  <= mm_a_mat;
        fill_b[0]  <= mm_b_vec;
        fill_idx   <= 1;
      end else begin
        if (fill_idx < 8) begin
          fill_a[fill_idx[2:0]] <= mm_a_mat;
          fill_b[fill_idx[2:0]] <= mm_b_vec;
        end
        fill_idx <= fill_idx + 1;
      end
    end
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one run and measures start-to-result_valid latency,
  // counting the start cycle and the result_valid cycle inclusively.
  task automatic applyStimulus(input logic [AW-1:0] base, output int lat);
    bit got;
    got = 1'b0;
    @(negedge clk);
    base_addr = base;
    start     = 1'b1;
    lat       = 1;
    while (!got && (lat < 400)) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 2) checkOutput("busy_run", 64'(busy), 64'd1);
      if (result_valid) got = 1'b1;
    end
    checkOutput("result_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_wren();
    int n;
    n = 0;
    while (!mm_wren && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wren_seen", 64'(mm_wren), 64'd1);
  endtask

  initial begin
    int lat;
    int rv0, clr0, tog0, wr0, runs0, acc0, st0, sb0;
    int n;

    rst_n          = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    stall_en       = 1'b0;
    stall_exp_addr = '0;
    for (int i = 0; i < 64; i++) mem_img[i] = '0;
    for (int i = 0; i < 8; i++) begin
      mem_img[i]      = 64'h1 << (8 * i);
      mem_img[16 + i] = 64'hFFFF_FFFF_FFFF_FFFF;
      mem_img[32 + i] = 64'h1 << (8 * i);
      mem_img[48 + i] = 64'(i + 1);
    end
    mem_img[8]  = 64'h0807_0605_0403_0201;
    mem_img[24] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_img[40] = 64'h0007_0605_0403_0201;
    mem_img[56] = 64'h0807_0605_0403_0203;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",     64'(busy),         64'd0);
    checkOutput("rst_rvalid",   64'(result_valid), 64'd0);
    checkOutput("rst_mem_read", 64'(mem_read),     64'd0);
    checkOutput("rst_wren",     64'(mm_wren),      64'd0);
    checkOutput("rst_clr",      64'(mm_clr),       64'd0);
    checkOutput("rst_addr",     64'(mem_addr),     64'd0);
    checkOutput("rst_a_mat",    64'(mm_a_mat),     64'd0);
    checkOutput("rst_result0",  64'(result[0]),    64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] identity A, B=1..8");
    rv0 = rv_total; clr0 = clr_total; tog0 = tog_total; wr0 = wren_total; runs0 = wren_runs;
    applyStimulus(32'h100, lat);
    checkOutput("id_latency", 64'(lat), 64'd25);
    repeat (5) @(negedge clk);
    checkOutput("id_rv_count",   64'(rv_total - rv0),      64'd1);
    checkOutput("id_clr_count",  64'(clr_total - clr0),    64'd1);
    checkOutput("id_rv_with_clr", 64'(tog_total - tog0),   64'd1);
    checkOutput("id_wren_cycles", 64'(wren_total - wr0),   64'd8);
    checkOutput("id_wren_runs",  64'(wren_runs - runs0),   64'd1);
    checkOutput("id_fill_a0",    fill_a[0], 64'h0000_0000_0000_0001);
    checkOutput("id_fill_a3",    fill_a[3], 64'h0000_0000_0100_0000);
    checkOutput("id_fill_b0",    64'(fill_b[0]), 64'd1);
    checkOutput("id_fill_b7",    64'(fill_b[7]), 64'd8);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("id_result%0d", i), 64'(result[i]), 64'(i + 1));
    checkOutput("id_busy_after", 64'(busy), 64'd0);

    $display("[TB] all 0xFF");
    applyStimulus(32'h110, lat);
    checkOutput("ff_latency", 64'(lat), 64'd25);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("ff_result%0d", i), 64'(result[i]), 64'h07F008);

    $display("[TB] stall on read 4");
    stall_en = 1'b1;
    stall_exp_addr = 32'h104;
    acc0 = acc_total; st0 = stall_total; sb0 = stall_bad;
    applyStimulus(32'h100, lat);
    checkOutput("st_latency", 64'(lat), 64'd28);
    repeat (3) @(negedge clk);
    stall_en = 1'b0;
    checkOutput("st_stall_cycles", 64'(stall_total - st0), 64'd3);
    checkOutput("st_addr_held",    64'(stall_bad - sb0),   64'd0);
    checkOutput("st_reads",        64'(acc_total - acc0),  64'd9);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("st_result%0d", i), 64'(result[i]), 64'(i + 1));

    $display("[TB] B[7]=0 timeout");
    rv0 = rv_total;
    applyStimulus(32'h120, lat);
    checkOutput("to_latency", 64'(lat), 64'd45);
    repeat (3) @(negedge clk);
    checkOutput("to_rv_count", 64'(rv_total - rv0), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++)
      checkOutput($sformatf("to_result%0d", i), 64'(result[i]), 64'(i + 1));
    checkOutput("to_result7", 64'(result[7]), 64'd0);

    $display("[TB] non-symmetric A (transpose)");
    applyStimulus(32'h130, lat);
    repeat (3) @(negedge clk);
    checkOutput("tr_fill_a0", fill_a[0], 64'h0807_0605_0403_0201);
    checkOutput("tr_fill_a1", fill_a[1], 64'h0);
    checkOutput("tr_fill_b0", 64'(fill_b[0]), 64'd3);
    checkOutput("tr_fill_b1", 64'(fill_b[1]), 64'd2);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("tr_result%0d", i), 64'(result[i]), 64'(3 * (i + 1)));

    $display("[TB] start during FILL");
    rv0 = rv_total; acc0 = acc_total;
    @(negedge clk);
    base_addr = 32'h100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_wren();
    base_addr = 32'h110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("sf_rv_count", 64'(rv_total - rv0),  64'd1);
    checkOutput("sf_reads",    64'(acc_total - acc0), 64'd9);
    checkOutput("sf_result0",  64'(result[0]), 64'd1);
    checkOutput("sf_result7",  64'(result[7]), 64'd8);

    $display("[TB] reset mid-FILL");
    rv0 = rv_total;
    @(negedge clk);
    base_addr = 32'h110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_wren();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mr_busy",     64'(busy),         64'd0);
    checkOutput("mr_rvalid",   64'(result_valid), 64'd0);
    checkOutput("mr_mem_read", 64'(mem_read),     64'd0);
    checkOutput("mr_wren",     64'(mm_wren),      64'd0);
    checkOutput("mr_clr",      64'(mm_clr),       64'd0);
    checkOutput("mr_addr",     64'(mem_addr),     64'd0);
    checkOutput("mr_a_mat",    64'(mm_a_mat),     64'd0);
    checkOutput("mr_b_vec",    64'(mm_b_vec),     64'd0);
    checkOutput("mr_result0",  64'(result[0]),    64'd0);
    checkOutput("mr_result7",  64'(result[7]),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (60) @(negedge clk);
    checkOutput("mr_no_rv", 64'(rv_total - rv0), 64'd0);
    applyStimulus(32'h110, lat);
    checkOutput("mr_next_latency", 64'(lat), 64'd25);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("mr_next_result%0d", i), 64'(result[i]), 64'h07F008);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
